triangle_phase_decoder: RTL

Recovers the 32-bit phase accumulator's upper half (phase[31:16]) from a stream of signed 16-bit triangle samples. It is the inverse of the triangle generator in the reference path and sits on the loop-back/measurement side of the PLL. The block:
- tracks slope direction to resolve the fold ambiguity,
- unfolds each sample back into a 16-bit phase,
- reports the per-sample phase increment and the period measured in samples,
- runs an acquisition/lock state machine.

---
 rtl/triangle_phase_decoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/triangle_phase_decoder.sv
// triangle_phase_decoder
// Inverts a folded triangle waveform back into the upper 16 bits of the
// generating phase accumulator. Slope direction resolves which half of the
// fold a sample lies on. The block also measures the waveform period in
// samples and runs an acquire/lock state machine that gates out_valid.
module triangle_phase_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int DEAD_BAND  = 2,
    parameter int PERIOD_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [15:0]  in_sample,
    output logic                out_valid,
    output logic [15:0]         phase_hi,
    output logic [15:0]         dphase,
    output logic [PERIOD_W-1:0] period,
    output logic                locked
);

    // The run counter only has to distinguish 0..LOCK_COUNT, so it saturates there.
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0]    RUN_LOCK = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic signed [16:0]  DB_POS   = 17'(DEAD_BAND);
    localparam logic signed [16:0]  DB_NEG   = -DB_POS;
    localparam logic signed [16:0]  HALF     = 17'sd16384;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [15:0]    prev_sample_q, prev_sample_d;
    logic [15:0]           prev_phase_q, prev_phase_d;
    logic                  dir_q, dir_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [15:0]           phase_hi_q, phase_hi_d;
    logic [15:0]           dphase_q, dphase_d;
    logic                  out_valid_q, out_valid_d;

    logic signed [16:0]    diff;
    logic signed [16:0]    sample_x;
    logic signed [16:0]    l_val;
    logic                  rising_dec;
    logic                  falling_dec;
    logic                  decided;
    logic                  new_dir;
    logic                  flip;
    logic                  turn;
    logic [15:0]           phase_next;
    logic [15:0]           dphase_next;
    logic [RUN_W-1:0]      run_inc;
    logic [RUN_W-1:0]      run_next;
    logic [PERIOD_W-1:0]   cnt_inc;

    // Fold distance from the trough limited to the 15-bit half-period range.
    function automatic logic [14:0] clamp_l(input logic signed [16:0] l);
        if (l < 17'sd0) begin
            return 15'd0;
        end else if (l > 17'sd32767) begin
            return 15'h7FFF;
        end else begin
            return l[14:0];
        end
    endfunction

    // Period counter sticks at all-ones rather than wrapping.
    function automatic logic [PERIOD_W-1:0] sat_inc_cnt(input logic [PERIOD_W-1:0] c);
        if (c == {PERIOD_W{1'b1}}) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    // Slope decision and unfolding of the incoming sample.
    always_comb begin
        sample_x    = {in_sample[15], in_sample};
        diff        = sample_x - {prev_sample_q[15], prev_sample_q};
        rising_dec  = (diff > DB_POS);
        falling_dec = (diff < DB_NEG);
        decided     = rising_dec | falling_dec;
        new_dir     = decided ? falling_dec : dir_q;
        l_val       = new_dir ? (HALF - sample_x) : (sample_x + HALF);
        phase_next  = {new_dir, clamp_l(l_val)};
        dphase_next = phase_next - prev_phase_q;
        flip        = decided && (new_dir != dir_q);
        turn        = dir_q && !new_dir;
        run_inc     = (run_q >= RUN_LOCK) ? run_q : (run_q + RUN_ONE);
        cnt_inc     = sat_inc_cnt(cnt_q);
        if (flip) begin
            run_next = RUN_ONE;
        end else if (decided) begin
            run_next = run_inc;
        end else begin
            run_next = run_q;
        end
    end

    // Next-state logic for the FSM, tracking state and registered outputs.
    always_comb begin
        state_d       = state_q;
        prev_sample_d = prev_sample_q;
        prev_phase_d  = prev_phase_q;
        dir_d         = dir_q;
        run_d         = run_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        phase_hi_d    = phase_hi_q;
        dphase_d      = dphase_q;
        out_valid_d   = 1'b0;

        if (in_valid) begin
            cnt_d = cnt_inc;
            case (state_q)
                S_IDLE: begin
                    prev_sample_d = in_sample;
                    run_d         = '0;
                    state_d       = S_ACQ;
                end
                S_ACQ, S_LOCK: begin
                    prev_sample_d = in_sample;
                    prev_phase_d  = phase_next;
                    dir_d         = new_dir;
                    run_d         = run_next;
                    if (turn) begin
                        period_d = cnt_q;
                        cnt_d    = CNT_ONE;
                    end
                    if (state_q == S_ACQ) begin
                        if (run_next >= RUN_LOCK) begin
                            state_d = S_LOCK;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        phase_hi_d  = phase_next;
                        dphase_d    = dphase_next;
                        // Two turns closer than LOCK_COUNT samples means the tone is gone.
                        if (flip && (run_q < RUN_LOCK)) begin
                            state_d = S_ACQ;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            prev_sample_q <= '0;
            prev_phase_q  <= '0;
            dir_q         <= 1'b0;
            run_q         <= '0;
            cnt_q         <= '0;
            period_q      <= '0;
            phase_hi_q    <= '0;
            dphase_q      <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_sample_q <= prev_sample_d;
            prev_phase_q  <= prev_phase_d;
            dir_q         <= dir_d;
            run_q         <= run_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            phase_hi_q    <= phase_hi_d;
            dphase_q      <= dphase_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign phase_hi  = phase_hi_q;
    assign dphase    = dphase_q;
    assign period    = period_q;
    assign locked    = (state_q == S_LOCK);

endmodule
